quidditch_play_core: RTL and testbench

Core gameplay engine for the quidditch/pong game. It moves two vertical player paddles from push-buttons and moves a ball and a decorative bludger on a fixed-step tick. It detects wall, paddle and goal events, and pulses a score output per goal. It sits under the top-level game controller, which owns the match timer and supplies `game_over`, and above the VGA renderer, which consumes all positions.

---
 rtl/quidditch_pkg.sv | 26 ++
 rtl/quidditch_play_core_paddle.sv | 53 +++++
 rtl/quidditch_play_core.sv | 216 +++++++++++++++++++++
 tb/tb_quidditch_play_core.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/quidditch_pkg.sv
// Shared field defaults, ball state encoding and velocity type for the quidditch gameplay core.
package quidditch_pkg;

    localparam int DEF_FIELD_WIDTH     = 640;
    localparam int DEF_FIELD_HEIGHT    = 480;
    localparam int DEF_PLAYER_RADIUS   = 20;
    localparam int DEF_BALL_RADIUS     = 8;
    localparam int DEF_GOAL_RADIUS     = 60;
    localparam int DEF_TEAM1_X         = 40;
    localparam int DEF_TEAM2_X         = 600;
    localparam int DEF_INITIAL_VER_POS = 240;
    localparam int DEF_PLAYER_FREQ     = 250000;
    localparam int DEF_BALL_FREQ       = 200000;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2
    } ball_state_e;

    typedef logic signed [1:0] vel_t;

    localparam vel_t VEL_POS = 2'sb01;
    localparam vel_t VEL_NEG = 2'sb11;

endpackage

// File: rtl/quidditch_play_core_paddle.sv
// One team paddle: free-running step tick plus up/down stepping clamped to the field.
module paddle_controller
    import quidditch_pkg::*;
#(
    parameter int FIELD_HEIGHT    = DEF_FIELD_HEIGHT,
    parameter int PLAYER_RADIUS   = DEF_PLAYER_RADIUS,
    parameter int INITIAL_VER_POS = DEF_INITIAL_VER_POS,
    parameter int MOVE_FREQ       = DEF_PLAYER_FREQ
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_i,
    input  logic       down_i,
    output logic [9:0] pos_o
);

    localparam int               CNT_W   = (MOVE_FREQ > 1) ? $clog2(MOVE_FREQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOVE_FREQ - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [9:0]       POS_MIN = 10'(PLAYER_RADIUS);
    localparam logic [9:0]       POS_MAX = 10'(FIELD_HEIGHT - 1 - PLAYER_RADIUS);
    localparam logic [9:0]       POS_RST = 10'(INITIAL_VER_POS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       pos_q, pos_d;
    logic             tick;

    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + CNT_ONE;
        pos_d = pos_q;
        if (tick) begin
            if (up_i && !down_i && pos_q != POS_MIN) begin
                pos_d = pos_q - 10'd1;
            end else if (down_i && !up_i && pos_q != POS_MAX) begin
                pos_d = pos_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            pos_q <= POS_RST;
        end else begin
            cnt_q <= cnt_d;
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/quidditch_play_core.sv
// Gameplay engine: two paddles, the ball serve/play/over machine with wall, paddle and goal
// detection, and the decorative bludger. All positions are registered for the renderer.
module quidditch_play_core
    import quidditch_pkg::*;
#(
    parameter int FIELD_WIDTH               = DEF_FIELD_WIDTH,
    parameter int FIELD_HEIGHT              = DEF_FIELD_HEIGHT,
    parameter int PLAYER_RADIUS             = DEF_PLAYER_RADIUS,
    parameter int BALL_RADIUS               = DEF_BALL_RADIUS,
    parameter int GOAL_RADIUS               = DEF_GOAL_RADIUS,
    parameter int TEAM1_X                   = DEF_TEAM1_X,
    parameter int TEAM2_X                   = DEF_TEAM2_X,
    parameter int INITIAL_VER_POS           = DEF_INITIAL_VER_POS,
    parameter int PLAYER_MOVEMENT_FREQUENCY = DEF_PLAYER_FREQ,
    parameter int BALL_MOVEMENT_FREQUENCY   = DEF_BALL_FREQ
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_over,
    input  logic        team1_vu_button,
    input  logic        team1_vd_button,
    input  logic        team2_vu_button,
    input  logic        team2_vd_button,
    output logic [9:0]  team1_ver_position,
    output logic [9:0]  team2_ver_position,
    output logic        score_to_team1,
    output logic        score_to_team2,
    output logic [18:0] x_position,
    output logic [18:0] y_position,
    output logic [18:0] x_blugger,
    output logic [18:0] y_blugger,
    output logic        game_on
);

    localparam int                BCNT_W   = (BALL_MOVEMENT_FREQUENCY > 1) ? $clog2(BALL_MOVEMENT_FREQUENCY) : 1;
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BALL_MOVEMENT_FREQUENCY - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);

    localparam logic [9:0] MID_X = 10'(FIELD_WIDTH / 2);
    localparam logic [9:0] MID_Y = 10'(FIELD_HEIGHT / 2);
    localparam logic [9:0] BR_U  = 10'(BALL_RADIUS);
    localparam logic [9:0] BOT_U = 10'(FIELD_HEIGHT - 1 - BALL_RADIUS);

    localparam logic signed [11:0] BR_S    = 12'(BALL_RADIUS);
    localparam logic signed [11:0] BOT_S   = 12'(FIELD_HEIGHT - 1 - BALL_RADIUS);
    localparam logic signed [11:0] RIGHT_S = 12'(FIELD_WIDTH - 1 - BALL_RADIUS);
    localparam logic signed [11:0] MIDY_S  = 12'(FIELD_HEIGHT / 2);
    localparam logic signed [11:0] GOAL_S  = 12'(GOAL_RADIUS);
    localparam logic signed [11:0] REACH_S = 12'(PLAYER_RADIUS + BALL_RADIUS);
    localparam logic signed [11:0] T1_FACE = 12'(TEAM1_X + PLAYER_RADIUS);
    localparam logic signed [11:0] T2_FACE = 12'(TEAM2_X - PLAYER_RADIUS);

    function automatic logic signed [11:0] abs12(input logic signed [11:0] v);
        return v[11] ? -v : v;
    endfunction

    function automatic logic [9:0] step10(input logic [9:0] p, input vel_t v);
        return p + {{8{v[1]}}, v};
    endfunction

    ball_state_e       state_q, state_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [9:0]        x_q, x_d, y_q, y_d, by_q, by_d;
    vel_t              vx_q, vx_d, vy_q, vy_d, sd_q, sd_d, bd_q, bd_d, vx_n, vy_n;
    logic              score1_q, score1_d, score2_q, score2_d, game_on_q, game_on_d;
    logic [9:0]        t1_pos, t2_pos;
    logic signed [11:0] xs, ys;
    logic ball_tick, any_button, in_goal, top_wall, bot_wall;
    logic hit1, hit2, left_edge, right_edge;

    paddle_controller #(
        .FIELD_HEIGHT(FIELD_HEIGHT), .PLAYER_RADIUS(PLAYER_RADIUS),
        .INITIAL_VER_POS(INITIAL_VER_POS), .MOVE_FREQ(PLAYER_MOVEMENT_FREQUENCY)
    ) u_team1 (
        .clk(clk), .rst(rst), .up_i(team1_vu_button), .down_i(team1_vd_button), .pos_o(t1_pos)
    );

    paddle_controller #(
        .FIELD_HEIGHT(FIELD_HEIGHT), .PLAYER_RADIUS(PLAYER_RADIUS),
        .INITIAL_VER_POS(INITIAL_VER_POS), .MOVE_FREQ(PLAYER_MOVEMENT_FREQUENCY)
    ) u_team2 (
        .clk(clk), .rst(rst), .up_i(team2_vu_button), .down_i(team2_vd_button), .pos_o(t2_pos)
    );

    // Collision detection and the velocity the ball would take this tick, from current position.
    always_comb begin
        xs         = {2'b00, x_q};
        ys         = {2'b00, y_q};
        any_button = team1_vu_button | team1_vd_button | team2_vu_button | team2_vd_button;
        in_goal    = abs12(ys - MIDY_S) <= GOAL_S;
        top_wall   = (ys <= BR_S) && (vy_q == VEL_NEG);
        bot_wall   = (ys >= BOT_S) && (vy_q == VEL_POS);
        hit1       = (vx_q == VEL_NEG) && ((xs - BR_S) == T1_FACE)
                     && (abs12(ys - $signed({2'b00, t1_pos})) <= REACH_S);
        hit2       = (vx_q == VEL_POS) && ((xs + BR_S) == T2_FACE)
                     && (abs12(ys - $signed({2'b00, t2_pos})) <= REACH_S);
        left_edge  = (xs <= BR_S) && (vx_q == VEL_NEG);
        right_edge = (xs >= RIGHT_S) && (vx_q == VEL_POS);

        vx_n = vx_q;
        vy_n = vy_q;
        if (top_wall) vy_n = VEL_POS;
        if (bot_wall) vy_n = VEL_NEG;
        if (hit1) begin
            vx_n = VEL_POS;
            if (team1_vu_button)      vy_n = VEL_NEG;
            else if (team1_vd_button) vy_n = VEL_POS;
        end
        if (hit2) begin
            vx_n = VEL_NEG;
            if (team2_vu_button)      vy_n = VEL_NEG;
            else if (team2_vd_button) vy_n = VEL_POS;
        end
        if (left_edge && !in_goal)  vx_n = VEL_POS;
        if (right_edge && !in_goal) vx_n = VEL_NEG;
    end

    always_comb begin
        ball_tick = (bcnt_q == BCNT_MAX);
        bcnt_d    = ball_tick ? '0 : bcnt_q + BCNT_ONE;
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        sd_d      = sd_q;
        by_d      = by_q;
        bd_d      = bd_q;
        score1_d  = 1'b0;
        score2_d  = 1'b0;
        game_on_d = game_on_q;

        if (game_over) begin
            state_d = ST_OVER;
        end else begin
            case (state_q)
                ST_SERVE: begin
                    if (any_button) begin
                        state_d   = ST_PLAY;
                        game_on_d = 1'b1;
                        vx_d      = sd_q;
                        vy_d      = VEL_POS;
                    end
                end
                ST_PLAY: begin
                    if (ball_tick) begin
                        if (by_q <= BR_U)       bd_d = VEL_POS;
                        else if (by_q >= BOT_U) bd_d = VEL_NEG;
                        by_d = step10(by_q, bd_d);
                        // A goal recentres the ball instead of moving it this tick.
                        if (left_edge && in_goal) begin
                            score2_d = 1'b1;
                            sd_d     = VEL_NEG;
                            x_d      = MID_X;
                            y_d      = MID_Y;
                            state_d  = ST_SERVE;
                        end else if (right_edge && in_goal) begin
                            score1_d = 1'b1;
                            sd_d     = VEL_POS;
                            x_d      = MID_X;
                            y_d      = MID_Y;
                            state_d  = ST_SERVE;
                        end else begin
                            vx_d = vx_n;
                            vy_d = vy_n;
                            x_d  = step10(x_q, vx_n);
                            y_d  = step10(y_q, vy_n);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SERVE;
            bcnt_q    <= '0;
            x_q       <= MID_X;
            y_q       <= MID_Y;
            vx_q      <= VEL_POS;
            vy_q      <= VEL_POS;
            sd_q      <= VEL_POS;
            by_q      <= BR_U;
            bd_q      <= VEL_POS;
            score1_q  <= 1'b0;
            score2_q  <= 1'b0;
            game_on_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            sd_q      <= sd_d;
            by_q      <= by_d;
            bd_q      <= bd_d;
            score1_q  <= score1_d;
            score2_q  <= score2_d;
            game_on_q <= game_on_d;
        end
    end

    assign team1_ver_position = t1_pos;
    assign team2_ver_position = t2_pos;
    assign score_to_team1     = score1_q;
    assign score_to_team2     = score2_q;
    assign x_position         = {9'd0, x_q};
    assign y_position         = {9'd0, y_q};
    assign x_blugger          = {9'd0, MID_X};
    assign y_blugger          = {9'd0, by_q};
    assign game_on            = game_on_q;

endmodule

// File: tb/tb_quidditch_play_core.sv
// Bench for quidditch_play_core on a small 64x48 field with single-clock ticks.
module tb_quidditch_play_core;

    localparam int FW = 64, FH = 48, BR = 2, PR = 4, GR = 6;
    localparam int T1X = 4, T2X = 59, INIT = 24;

    typedef logic [98:0] vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, game_over, t1u, t1d, t2u, t2d;
    logic [9:0]  t1p, t2p;
    logic        s1, s2, gon;
    logic [18:0] xp, yp, xb, yb;

    quidditch_play_core #(
        .FIELD_WIDTH(FW), .FIELD_HEIGHT(FH), .PLAYER_RADIUS(PR), .BALL_RADIUS(BR),
        .GOAL_RADIUS(GR), .TEAM1_X(T1X), .TEAM2_X(T2X), .INITIAL_VER_POS(INIT),
        .PLAYER_MOVEMENT_FREQUENCY(1), .BALL_MOVEMENT_FREQUENCY(1)
    ) dut (
        .clk(clk), .rst(rst), .game_over(game_over),
        .team1_vu_button(t1u), .team1_vd_button(t1d),
        .team2_vu_button(t2u), .team2_vd_button(t2d),
        .team1_ver_position(t1p), .team2_ver_position(t2p),
        .score_to_team1(s1), .score_to_team2(s2),
        .x_position(xp), .y_position(yp), .x_blugger(xb), .y_blugger(yb),
        .game_on(gon)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t exp_q[$];

    // Reference model state: st 0=serve 1=play 2=over
    int m_t1, m_t2, m_st, m_x, m_y, m_vx, m_vy, m_sd, m_by, m_bd, m_gon, m_s1, m_s2;

    task automatic check_vec(input string tag, input vec_t got, input vec_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic vec_t dut_vec();
        return {t1p, t2p, s1, s2, xp, yp, xb, yb, gon};
    endfunction

    function automatic vec_t model_vec();
        return {10'(m_t1), 10'(m_t2), 1'(m_s1), 1'(m_s2), 19'(m_x), 19'(m_y),
                19'(FW / 2), 19'(m_by), 1'(m_gon)};
    endfunction

    task automatic model_step();
        int nt1, nt2, vx, vy;
        bit goal;
        if (rst) begin
            m_t1 = INIT; m_t2 = INIT; m_st = 0; m_x = FW / 2; m_y = FH / 2;
            m_vx = 1; m_vy = 1; m_sd = 1; m_by = BR; m_bd = 1;
            m_gon = 0; m_s1 = 0; m_s2 = 0;
            return;
        end
        nt1 = m_t1;
        if (t1u && !t1d && m_t1 > PR) nt1 = m_t1 - 1;
        if (t1d && !t1u && m_t1 < FH - 1 - PR) nt1 = m_t1 + 1;
        nt2 = m_t2;
        if (t2u && !t2d && m_t2 > PR) nt2 = m_t2 - 1;
        if (t2d && !t2u && m_t2 < FH - 1 - PR) nt2 = m_t2 + 1;
        m_s1 = 0;
        m_s2 = 0;
        if (game_over) begin
            m_st = 2;
        end else if (m_st == 0) begin
            if (t1u || t1d || t2u || t2d) begin
                m_st = 1; m_gon = 1; m_vx = m_sd; m_vy = 1;
            end
        end else if (m_st == 1) begin
            vx = m_vx; vy = m_vy; goal = 0;
            if (m_y <= BR && m_vy < 0) vy = 1;
            if (m_y >= FH - 1 - BR && m_vy > 0) vy = -1;
            if (m_vx < 0 && m_x - BR == T1X + PR && iabs(m_y - m_t1) <= PR + BR) begin
                vx = 1;
                if (t1u) vy = -1; else if (t1d) vy = 1;
            end
            if (m_vx > 0 && m_x + BR == T2X - PR && iabs(m_y - m_t2) <= PR + BR) begin
                vx = -1;
                if (t2u) vy = -1; else if (t2d) vy = 1;
            end
            if (m_x <= BR && m_vx < 0) begin
                if (iabs(m_y - FH / 2) <= GR) begin goal = 1; m_s2 = 1; m_sd = -1; end
                else vx = 1;
            end
            if (m_x >= FW - 1 - BR && m_vx > 0) begin
                if (iabs(m_y - FH / 2) <= GR) begin goal = 1; m_s1 = 1; m_sd = 1; end
                else vx = -1;
            end
            if (goal) begin
                m_x = FW / 2; m_y = FH / 2; m_st = 0;
            end else begin
                m_vx = vx; m_vy = vy; m_x = m_x + vx; m_y = m_y + vy;
            end
            if (m_by <= BR) m_bd = 1;
            else if (m_by >= FH - 1 - BR) m_bd = -1;
            m_by = m_by + m_bd;
        end
        m_t1 = nt1;
        m_t2 = nt2;
    endtask

    task automatic cyc();
        model_step();
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        check_vec("cycle", dut_vec(), exp_q.pop_front());
    endtask

    vec_t rst_vec;
    int   fx, fy, fby;
    bit   seen1, seen2, done1;

    initial begin
        rst_vec = {10'd24, 10'd24, 1'b0, 1'b0, 19'd32, 19'd24, 19'd32, 19'd2, 1'b0};
        rst = 1'b1; game_over = 1'b0; t1u = 1'b0; t1d = 1'b0; t2u = 1'b0; t2d = 1'b0;
        repeat (3) cyc();
        check_vec("reset_state", dut_vec(), rst_vec);
        rst = 1'b0;
        repeat (100) cyc();
        check_vec("idle_100", dut_vec(), rst_vec);

        // Team1 up serves the ball and drives the paddle to its top limit.
        t1u = 1'b1;
        repeat (22) cyc();
        check_vec("ball_at_bottom", 99'({xp, yp}), 99'({19'd53, 19'd45}));
        cyc();
        check_vec("bottom_wall", 99'({xp, yp}), 99'({19'd54, 19'd44}));
        repeat (7) cyc();
        check_vec("t1_top", 99'(t1p), 99'(4));
        check_vec("game_on", 99'(gon), 99'(1));
        t1d = 1'b1;
        repeat (10) cyc();
        check_vec("t1_both_hold", 99'(t1p), 99'(4));
        t1u = 1'b0; t1d = 1'b0;

        // Paddle 2 driven down to meet the ball at x=53, up pressed at contact.
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        t2d = 1'b1;
        cyc();
        check_vec("serve", 99'({gon, xp, yp}), 99'({1'b1, 19'd32, 19'd24}));
        cyc();
        check_vec("first_move", 99'({xp, yp}), 99'({19'd33, 19'd25}));
        repeat (20) cyc();
        check_vec("pre_contact", 99'({xp, yp, t2p}), 99'({19'd53, 19'd45, 10'd43}));
        t2d = 1'b0; t2u = 1'b1;
        cyc();
        check_vec("paddle2_hit", 99'({xp, yp}), 99'({19'd52, 19'd44}));
        t2u = 1'b0;
        cyc();
        check_vec("after_hit", 99'({xp, yp}), 99'({19'd51, 19'd43}));

        // Paddles parked at the top while the ball plays out to goals.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        t1u = 1'b1; t2u = 1'b1;
        seen1 = 0; seen2 = 0; done1 = 0;
        for (int i = 0; i < 3000 && !done1; i++) begin
            cyc();
            if (s2 === 1'b1 && !seen2) begin
                seen2 = 1;
                check_vec("goal2_centre", 99'({xp, yp}), 99'({19'd32, 19'd24}));
            end
            if (s1 === 1'b1) begin
                seen1 = 1;
                check_vec("goal1_centre", 99'({xp, yp}), 99'({19'd32, 19'd24}));
                cyc();
                check_vec("goal1_width", 99'({s1, xp}), 99'({1'b0, 19'd32}));
                cyc();
                check_vec("reserve_dir", 99'(xp), 99'(33));
                done1 = 1;
            end
        end
        check_vec("goal_seen", 99'({seen1, seen2}), 99'({1'b1, 1'b1}));
        t1u = 1'b0; t2u = 1'b0;

        // game_over freezes ball and bludger while paddles keep moving.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        t1d = 1'b1;
        cyc();
        t1d = 1'b0;
        repeat (10) cyc();
        game_over = 1'b1;
        cyc();
        fx = m_x; fy = m_y; fby = m_by;
        for (int i = 0; i < 50; i++) begin
            t1u = (i < 25);
            cyc();
            check_vec("frozen", 99'({xp, yp, yb, s1, s2, gon}),
                      99'({19'(fx), 19'(fy), 19'(fby), 1'b0, 1'b0, 1'b1}));
        end
        t1u = 1'b0;
        rst = 1'b1;
        cyc();
        check_vec("reset_after_over", dut_vec(), rst_vec);
        rst = 1'b0; game_over = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
